// File: rtl/postadder_operand_fetch.sv
// Burst read sequencer feeding postadder: issues operand RAM reads, tracks the fixed
// read latency with a tag pipeline and buffers {data, ctrl, last} in a FWFT FIFO.
//
// state | meaning
// IDLE  | cmd_ready high; waiting for a command (bad addresses only set cmd_err)
// ISSUE | one RAM read per cycle while credit allows; back to IDLE after last word
module postadder_operand_fetch #(
    parameter int DATA_W     = 272,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 141,
    parameter int RD_LAT     = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic [14:0]       cmd_ctrl,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_doutb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [14:0]       out_ctrl,
    output logic              out_last,
    output logic              cmd_err,
    output logic              busy
);

    localparam int CTRL_W = 15;
    localparam int TAG_W  = CTRL_W + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t              state;
    logic [7:0]          remaining;
    logic [CTRL_W-1:0]   ctrl_q;
    logic [ADDR_W-1:0]   addr_next;
    logic                cmd_fire;
    logic                addr_bad;
    logic                credit;
    logic                issue;
    logic                push;
    logic                pop;
    logic [CNT_W-1:0]    inflight;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W:0]      outstanding;

    logic [RD_LAT-1:0]   pipe_vld;
    logic [TAG_W-1:0]    pipe_tag [RD_LAT];

    logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
    logic [TAG_W-1:0]    fifo_tag  [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [TAG_W-1:0]    head_tag;

    always_comb begin
        cmd_fire    = cmd_valid && cmd_ready;
        addr_bad    = {1'b0, cmd_addr} >= (ADDR_W + 1)'(DEPTH);
        outstanding = {1'b0, fifo_count} + {1'b0, inflight};
        credit      = outstanding < (CNT_W + 1)'(FIFO_DEPTH);
        issue       = (state == ISSUE) && credit;
        addr_next   = (ram_addrb == ADDR_W'(DEPTH - 1)) ? '0 : ram_addrb + ADDR_W'(1);
        push        = pipe_vld[RD_LAT-1];
        pop         = out_valid && out_ready;
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(pipe_vld[i]);
        end
    end

    // ram_addrb doubles as the burst address pointer: the word issued in a cycle
    // is the one whose address is on the RAM port during that cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            ram_addrb <= '0;
            remaining <= '0;
            ctrl_q    <= '0;
            cmd_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_fire) begin
                        if (addr_bad) begin
                            cmd_err <= 1'b1;
                        end else begin
                            ram_addrb <= cmd_addr;
                            remaining <= cmd_len;
                            ctrl_q    <= cmd_ctrl;
                            cmd_ready <= 1'b0;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        ram_addrb <= addr_next;
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd0) begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    // Tag pipeline mirrors the RAM latency; a cleared valid discards stale RAM data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= issue;
            pipe_tag[0] <= {ctrl_q, remaining == 8'd0};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= ram_doutb;
            fifo_tag[wr_ptr]  <= pipe_tag[RD_LAT-1];
        end
    end

    // Head entry is masked while empty so the outputs read as zero after reset.
    always_comb begin
        out_valid = fifo_count != '0;
        head_tag  = fifo_tag[rd_ptr];
        out_data  = out_valid ? fifo_data[rd_ptr] : '0;
        out_ctrl  = out_valid ? head_tag[TAG_W-1:1] : '0;
        out_last  = out_valid && head_tag[0];
        busy      = (state != IDLE) || (inflight != '0) || (fifo_count != '0);
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && (fifo_count == CNT_W'(FIFO_DEPTH)) && !pop));

endmodule
